// File: rtl/multi_ch_clk_div_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master drives enables, clears and divisor writes; the slave returns per-channel status.
interface multi_ch_clk_div_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              sync_clr;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [CNT_W-1:0]  wr_high;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, sync_clr, wr_en, wr_ch, wr_div, wr_high,
    input  pend, div_clk, tick
  );

  modport slave (
    input  en, sync_clr, wr_en, wr_ch, wr_div, wr_high,
    output pend, div_clk, tick
  );
endinterface

// File: rtl/multi_ch_clk_div.sv
// Multi-channel clock divider: per-channel programmable period and high time with a
// shadow register that swaps in on the period wrap so running outputs never glitch.
module multi_ch_clk_div #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int DEF_DIV  = 100_000_000,
  parameter int DEF_HIGH = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  multi_ch_clk_div_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_HIGH);

  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] div_v;
  logic [NUM_CH-1:0] tick_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, p_act, h_act, p_sh, h_sh;
    logic             run_q, pend_q, div_q, tick_q;
    logic             hit, running, direct, to_shadow, wrap;
    logic [CNT_W-1:0] cnt_nx, p_nx, h_nx, p_eff, p_eff_nx, h_eff_nx;

    always_comb begin
      hit       = bus.wr_en && (bus.wr_ch == CH_W'(c));
      running   = bus.en[c] && !bus.sync_clr;
      direct    = hit && !running;
      to_shadow = hit && running;
      p_eff     = (p_act < TWO) ? TWO : p_act;
      // run_q low means this is the first enabled edge: hold phase 0 for one cycle
      wrap      = running && run_q && (cnt == p_eff - ONE);

      cnt_nx = cnt + ONE;
      if (!running || !run_q || wrap) cnt_nx = '0;

      p_nx = p_act;
      h_nx = h_act;
      if (direct) begin
        p_nx = bus.wr_div;
        h_nx = bus.wr_high;
      end else if (wrap && pend_q) begin
        p_nx = p_sh;
        h_nx = h_sh;
      end

      p_eff_nx = (p_nx < TWO) ? TWO : p_nx;
      h_eff_nx = (h_nx > p_eff_nx - ONE) ? p_eff_nx - ONE : h_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt    <= '0;
        p_act  <= DEF_DIV_C;
        h_act  <= DEF_HIGH_C;
        p_sh   <= '0;
        h_sh   <= '0;
        run_q  <= 1'b0;
        pend_q <= 1'b0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt   <= cnt_nx;
        p_act <= p_nx;
        h_act <= h_nx;
        run_q <= bus.en[c];
        if (direct) begin
          p_sh   <= '0;
          h_sh   <= '0;
          pend_q <= 1'b0;
        end else if (to_shadow) begin
          p_sh   <= bus.wr_div;
          h_sh   <= bus.wr_high;
          pend_q <= 1'b1;
        end else if (wrap) begin
          pend_q <= 1'b0;
        end
        div_q  <= running && (h_eff_nx != '0) && (cnt_nx >= p_eff_nx - h_eff_nx);
        tick_q <= running && (cnt_nx == p_eff_nx - ONE);
      end
    end

    assign pend_v[c] = pend_q;
    assign div_v[c]  = div_q;
    assign tick_v[c] = tick_q;
  end

  assign bus.pend    = pend_v;
  assign bus.div_clk = div_v;
  assign bus.tick    = tick_v;
endmodule

// File: tb/tb_multi_ch_clk_div.sv
// Self-checking bench for multi_ch_clk_div: a phase-position model compared every cycle,
// plus directed measurements of period, high time and latency against literal values.
module tb_multi_ch_clk_div;
  localparam int NC = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_ch_clk_div_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  multi_ch_clk_div #(.NUM_CH(NC), .CNT_W(CW), .DEF_DIV(10), .DEF_HIGH(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_chk  = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: position within the current period plus active/pending divisor values
  int m_p[NC], m_h[NC], m_sp[NC], m_sh[NC], m_pos[NC];
  bit m_pend[NC], m_started[NC];
  logic [NC-1:0] e_div, e_tick, e_pend;

  function automatic int peff(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int heff(input int p, input int h);
    return (h > peff(p) - 1) ? peff(p) - 1 : h;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        m_p[c] = 10; m_h[c] = 5; m_sp[c] = 0; m_sh[c] = 0; m_pos[c] = 0;
        m_pend[c] = 1'b0; m_started[c] = 1'b0;
      end
      e_div = '0; e_tick = '0; e_pend = '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit hit;
        hit = bus.wr_en && (int'(bus.wr_ch) == c);
        if (bus.sync_clr || !bus.en[c]) begin
          if (hit) begin
            m_p[c] = int'(bus.wr_div); m_h[c] = int'(bus.wr_high); m_pend[c] = 1'b0;
          end
          m_pos[c] = 0;
          m_started[c] = bus.en[c];
          e_div[c] = 1'b0;
          e_tick[c] = 1'b0;
        end else begin
          if (!m_started[c]) begin
            m_pos[c] = 0;
            m_started[c] = 1'b1;
          end else if (m_pos[c] == peff(m_p[c]) - 1) begin
            m_pos[c] = 0;
            if (m_pend[c]) begin
              m_p[c] = m_sp[c]; m_h[c] = m_sh[c]; m_pend[c] = 1'b0;
            end
          end else begin
            m_pos[c]++;
          end
          if (hit) begin
            m_sp[c] = int'(bus.wr_div); m_sh[c] = int'(bus.wr_high); m_pend[c] = 1'b1;
          end
          e_tick[c] = (m_pos[c] == peff(m_p[c]) - 1);
          e_div[c]  = (heff(m_p[c], m_h[c]) > 0) &&
                      (m_pos[c] >= peff(m_p[c]) - heff(m_p[c], m_h[c]));
        end
        e_pend[c] = m_pend[c];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on)
      chk("cycle", {bus.pend, bus.div_clk, bus.tick}, {e_pend, e_div, e_tick});
  end

  task automatic wr(input int c, input int d, input int h);
    bus.wr_en = 1'b1; bus.wr_ch = 2'(c); bus.wr_div = 16'(d); bus.wr_high = 16'(h);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick[c] && n < 100);
    if (!bus.tick[c]) chk("tick_timeout", 64'd0, 64'd1);
  endtask

  task automatic measure(input int c, output int per, output int hi);
    wait_tick(c);
    per = 0; hi = 0;
    do begin
      @(negedge clk);
      per++;
      if (bus.div_clk[c]) hi++;
    end while (!bus.tick[c] && per < 100);
  endtask

  initial begin
    int per, hi, n;
    bus.en = '0; bus.sync_clr = 1'b0; bus.wr_en = 1'b0;
    bus.wr_ch = '0; bus.wr_div = '0; bus.wr_high = '0;

    @(negedge clk);
    chk("reset_out", {bus.pend, bus.div_clk, bus.tick}, 64'd0);
    cmp_on = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // default 10/5 on channel 0
    bus.en = 3'b001;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tick[0] && n < 50);
    chk("first_tick_lat", 64'(n), 64'd10);
    measure(0, per, hi);
    chk("def_period", 64'(per), 64'd10);
    chk("def_high", 64'(hi), 64'd5);
    chk("ch1_idle", {bus.div_clk[1], bus.tick[1]}, 64'd0);

    // reprogram running channel 0 at cnt=3
    repeat (4) @(negedge clk);
    wr(0, 4, 1);
    chk("pend_set", 64'(bus.pend[0]), 64'd1);
    wait_tick(0);
    chk("pend_hold", 64'(bus.pend[0]), 64'd1);
    @(negedge clk);
    chk("pend_clr_wrap", 64'(bus.pend[0]), 64'd0);
    measure(0, per, hi);
    chk("new_period", 64'(per), 64'd4);
    chk("new_high", 64'(hi), 64'd1);

    // clamp on a disabled channel
    wr(1, 1, 7);
    chk("pend1_direct", 64'(bus.pend[1]), 64'd0);
    bus.en = 3'b011;
    measure(1, per, hi);
    chk("clamp_period", 64'(per), 64'd2);
    chk("clamp_high", 64'(hi), 64'd1);

    // H=0 keeps ticks, output low
    wr(0, 4, 0);
    wait_tick(0);
    measure(0, per, hi);
    chk("h0_period", 64'(per), 64'd4);
    chk("h0_high", 64'(hi), 64'd0);

    // out-of-range channel write is ignored
    wr(3, 7, 3);
    chk("oor_pend", 64'(bus.pend), 64'd0);
    measure(0, per, hi);
    chk("oor_period0", 64'(per), 64'd4);
    measure(1, per, hi);
    chk("oor_period1", 64'(per), 64'd2);

    // sync clear aligns phases
    bus.sync_clr = 1'b1;
    @(negedge clk);
    bus.sync_clr = 1'b0;
    chk("clr_out", {bus.div_clk, bus.tick}, 64'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tick[0] && n < 50);
    chk("clr_tick_lat", 64'(n), 64'd3);
    chk("clr_coincide", 64'(bus.tick[1]), 64'd1);

    // async reset while a write is pending
    wait_tick(0);
    wr(0, 8, 2);
    chk("pend_before_rst", 64'(bus.pend[0]), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_out", {bus.pend, bus.div_clk, bus.tick}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    measure(0, per, hi);
    chk("post_rst_period", 64'(per), 64'd10);
    chk("post_rst_high", 64'(hi), 64'd5);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_chk);
    $fatal(1);
  end
endmodule
